// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling driven by a
// baud counter, and a single-entry valid/ready holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nx;
  logic                 sync1, rxd_s;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_tick, mid_tick;
  logic                 shift_en, load, ovr_set, ferr_set;

  assign bit_tick = (baud_cnt == CNT_LAST);
  assign mid_tick = (baud_cnt == CNT_MID);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    load     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    case (state)
      S_IDLE:  if (!rxd_s) state_nx = S_START;
      S_START: if (mid_tick) state_nx = rxd_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (rxd_s) begin
            if (!rx_valid || rx_ready) load = 1'b1;
            else                       ovr_set = 1'b1;
            state_nx = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: if (rxd_s) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shifting in from the MSB end places the first-received bit at bit 0
  // once DATA_BITS samples have been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_nx != state || bit_tick) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;
      if (state != S_DATA) bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= ferr_set;
      overrun   <= ovr_set;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 asynchronous link. It is the receive end of the single-wire serial interface that the team's transmitter drives.
- Oversamples the incoming line with the system clock, recovers bytes LSB-first, and presents them on a valid/ready byte interface.
- Reports framing errors and overruns to the consuming logic.

Parameters:
- CLKS_PER_BIT, 16: system clocks per bit period. Must be at least 4 and even.
- DATA_BITS, 8: data bits per frame. Legal values are 5 to 8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid is high.
- rx_valid  output  1  byte available; held until consumed.
- rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid and rx_ready are both high.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a new byte completed while rx_valid was still high; that new byte is dropped.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately forces the reset state below, regardless of clk.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; bit counter and baud counter = 0.
  - Both synchronizer flops = 1.
- Synchronizer:
  - rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
  - rxd_s lags rxd by 2 clocks.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1.
  - Cleared on every state entry.
  - "Bit tick" means the counter equals CLKS_PER_BIT-1.
- IDLE:
  - Stays here while rxd_s=1.
  - rxd_s=0 moves to START and clears the counter.
- START:
  - At count CLKS_PER_BIT/2-1 (mid start bit), rxd_s is sampled.
  - Sample 0: go to DATA, counter cleared, bit index = 0.
  - Sample 1: false start; return to IDLE with no flag raised.
- DATA:
  - On each bit tick, rxd_s is shifted into the shift register at position bit index (LSB first), and bit index increments.
  - After DATA_BITS ticks, go to STOP.
  - Sample points are therefore mid-bit: CLKS_PER_BIT/2 + k*CLKS_PER_BIT clocks after the synchronized falling edge, for k = 1..DATA_BITS.
- STOP: sample rxd_s on the bit tick.
  - Sample 1 and rx_valid=0, or sample 1 with rx_valid=1 and rx_ready=1 in the same cycle: load rx_data from the shift register, set rx_valid=1 on the next edge, then go to IDLE.
  - Sample 1, rx_valid=1 and rx_ready=0: pulse overrun. rx_data is unchanged and keeps the old byte. Go to IDLE.
  - Sample 0: pulse frame_err. No data is loaded. Go to BREAK.
- BREAK:
  - Wait until rxd_s=1, then go to IDLE.
  - Prevents a held-low line (break condition) from being read as a stream of 0x00 frames.
- Output handshake:
  - rx_valid clears on the edge after rx_valid & rx_ready, unless a new byte loads on that same edge; in that case rx_valid stays 1 and rx_data takes the new byte.
  - rx_ready has no effect while rx_valid=0.
- Latency:
  - rx_valid rises 1 clock after the stop-bit sample, i.e. CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clocks after the synchronized falling edge.
  - With defaults that is 153 clocks, or 155 clocks after the rxd edge.
- Reception continues while rx_valid is high; only the completion of a frame into a full holding register causes an overrun.
- Reset asserted mid-frame:
  - Partial byte discarded; all outputs return to reset values.
  - After rst_n is released, a line that is still low is treated as a new start edge. An immediate false start or framing error in that case is acceptable and is not masked.

Test Plan:
- Defaults. Send 0x55 then 0xA3 back-to-back, with rx_ready tied to 1. Required: rx_valid pulses twice, with rx_data=0x55 and then 0xA3. First rx_valid is 155 clocks after the first rxd fall. frame_err=0 and overrun=0 throughout.
- rxd low for 6 clocks, then high. Required: no rx_valid, no frame_err. busy returns to 0 at clock CLKS_PER_BIT/2 after the synchronized edge. A frame 0x3C sent afterwards is received correctly.
- Send 0x7E with its stop bit driven low, then hold rxd low for 40 bit periods, then high. Required: exactly one frame_err pulse, no rx_valid, and no further frames while the line is low. A following 0x81 is received correctly.
- rx_ready=0. Send 0x11 then 0x22. Required: rx_valid=1 with rx_data=0x11; an overrun pulse at the end of the second frame; rx_data stays 0x11. Then raise rx_ready for 1 clock: rx_valid goes to 0.
- Hold rx_valid=1 with 0x11, and assert rx_ready in exactly the cycle the 0x22 stop bit is sampled. Required: rx_valid stays 1, rx_data=0x22, overrun=0.
- Assert rst_n low during data bit 4 of 0xF0, hold for 3 clocks, then release with the line idle high. Required: rx_valid=0 and busy=0 immediately on reset assertion. A next frame 0x0F gives rx_data=0x0F.
